// File: rtl/tis_exec_node.sv
// TIS-100 execution node: ACC/BAK data path, PC and jump logic, and blocking
// valid/ready neighbour ports. Port reads and writes stall until the neighbour completes.
module tis_exec_node #(
  parameter int DATA_W = 8,
  parameter int NPORTS = 4,
  parameter int PC_W   = 4,
  localparam int INSTR_W = 10 + DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PC_W:0]              prog_len,
  input  logic [INSTR_W-1:0]         instr,
  output logic [PC_W-1:0]            pc,
  input  logic [NPORTS*DATA_W-1:0]   in_data,
  input  logic [NPORTS-1:0]          in_valid,
  output logic [NPORTS-1:0]          in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [NPORTS-1:0]          out_valid,
  input  logic [NPORTS-1:0]          out_ready,
  output logic [DATA_W-1:0]          acc,
  output logic                       stalled
);

  localparam int SW = ((DATA_W > PC_W + 1) ? DATA_W : PC_W + 1) + 1;
  localparam logic [2:0] NP3 = 3'(NPORTS);
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {RUN, RD_WAIT, WR_WAIT} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_MOV, OP_SWP, OP_SAV, OP_ADD, OP_SUB, OP_NEG,
    OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ, OP_JRO
  } opcode_t;

  state_t              state;
  logic [DATA_W-1:0]   bak;

  opcode_t             op;
  logic [2:0]          src, dst;
  logic [DATA_W-1:0]   imm, port_word, src_val;
  logic                port_valid, src_port, dst_port, reading, src_ok;
  logic [DATA_W:0]     add_ext, sub_ext, neg_ext;
  logic [DATA_W-1:0]   add_sat, sub_sat, neg_sat;
  logic [PC_W:0]       plen_eff, last;
  logic [PC_W-1:0]     seq_pc, jmp_pc, jro_pc, next_pc;
  logic signed [SW-1:0] jro_sum;
  logic                acc_zero, acc_neg;

  function automatic logic [DATA_W-1:0] sat(input logic [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1]) return v[DATA_W] ? MIN_V : MAX_V;
    return v[DATA_W-1:0];
  endfunction

  always_comb begin
    op  = opcode_t'(instr[INSTR_W-1 -: 4]);
    src = instr[INSTR_W-5 -: 3];
    dst = instr[INSTR_W-8 -: 3];
    imm = instr[DATA_W-1:0];

    src_port = (op inside {OP_MOV, OP_ADD, OP_SUB, OP_JRO}) && (src < NP3);
    dst_port = (op == OP_MOV) && (dst < NP3);

    port_word  = '0;
    port_valid = 1'b0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (src == 3'(p)) begin
        port_word  = in_data[p*DATA_W +: DATA_W];
        port_valid = in_valid[p];
      end
    end

    reading = src_port && (state != WR_WAIT) && !reset;
    in_ready = '0;
    for (int unsigned p = 0; p < NPORTS; p++)
      in_ready[p] = reading && (src == 3'(p));
    src_ok  = !src_port || port_valid;
    stalled = (state != RUN) || (src_port && !port_valid);

    if (src_port)         src_val = port_word;
    else if (src == 3'd4) src_val = acc;
    else if (src == 3'd6) src_val = imm;
    else                  src_val = '0;

    add_ext = {acc[DATA_W-1], acc} + {src_val[DATA_W-1], src_val};
    sub_ext = {acc[DATA_W-1], acc} - {src_val[DATA_W-1], src_val};
    neg_ext = '0 - {acc[DATA_W-1], acc};
    add_sat = sat(add_ext);
    sub_sat = sat(sub_ext);
    neg_sat = sat(neg_ext);

    plen_eff = (prog_len == '0) ? (PC_W+1)'(1) : prog_len;
    last     = plen_eff - 1'b1;
    seq_pc   = ({1'b0, pc} == last) ? '0 : pc + 1'b1;
    jmp_pc   = ({1'b0, imm[PC_W-1:0]} >= plen_eff) ? last[PC_W-1:0] : imm[PC_W-1:0];

    // Both operands are widened so the sum cannot overflow before clamping.
    jro_sum = SW'($signed(src_val)) + $signed(SW'(pc));
    if (jro_sum < 0)                        jro_pc = '0;
    else if (jro_sum > $signed(SW'(last)))  jro_pc = last[PC_W-1:0];
    else                                    jro_pc = jro_sum[PC_W-1:0];

    acc_zero = (acc == '0);
    acc_neg  = acc[DATA_W-1];
    case (op)
      OP_JMP:  next_pc = jmp_pc;
      OP_JEZ:  next_pc = acc_zero ? jmp_pc : seq_pc;
      OP_JNZ:  next_pc = !acc_zero ? jmp_pc : seq_pc;
      OP_JGZ:  next_pc = (!acc_zero && !acc_neg) ? jmp_pc : seq_pc;
      OP_JLZ:  next_pc = acc_neg ? jmp_pc : seq_pc;
      OP_JRO:  next_pc = jro_pc;
      default: next_pc = seq_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= '0;
      acc       <= '0;
      bak       <= '0;
      out_data  <= '0;
      out_valid <= '0;
    end else begin
      case (state)
        RUN, RD_WAIT: begin
          if (!src_ok) begin
            state <= RD_WAIT;
          end else if (dst_port) begin
            out_data <= src_val;
            for (int unsigned q = 0; q < NPORTS; q++)
              out_valid[q] <= (dst == 3'(q));
            state <= WR_WAIT;
          end else begin
            case (op)
              OP_MOV:  if (dst == 3'd4) acc <= src_val;
              OP_SWP:  begin acc <= bak; bak <= acc; end
              OP_SAV:  bak <= acc;
              OP_ADD:  acc <= add_sat;
              OP_SUB:  acc <= sub_sat;
              OP_NEG:  acc <= neg_sat;
              default: ;
            endcase
            pc    <= next_pc;
            state <= RUN;
          end
        end
        WR_WAIT: begin
          if (|(out_valid & out_ready)) begin
            out_valid <= '0;
            pc        <= seq_pc;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_tis_exec_node.sv
// Directed bench for tis_exec_node: arithmetic, saturation, jumps, port stalls
// and reset abandonment, checked against a queue of bench-computed expectations.
module tb_tis_exec_node;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int PW = 4;
  localparam int IW = 10 + DW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [PW:0]     prog_len = 5'd1;
  logic [IW-1:0]   instr;
  logic [PW-1:0]   pc;
  logic [NP*DW-1:0] in_data = '0;
  logic [NP-1:0]   in_valid = '0;
  logic [NP-1:0]   in_ready;
  logic [DW-1:0]   out_data;
  logic [NP-1:0]   out_valid;
  logic [NP-1:0]   out_ready = '0;
  logic [DW-1:0]   acc;
  logic            stalled;

  logic [IW-1:0]   mem [16];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  assign instr = mem[pc];

  tis_exec_node #(.DATA_W(DW), .NPORTS(NP), .PC_W(PW)) dut (
    .clk(clk), .reset(reset), .prog_len(prog_len), .instr(instr), .pc(pc),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .stalled(stalled)
  );

  function automatic logic [IW-1:0] ins(input int op, input int s, input int d, input int imm);
    return {op[3:0], s[2:0], d[2:0], imm[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  task automatic do_reset(input logic [PW:0] len);
    reset = 1'b1;
    prog_len = len;
    in_valid = '0;
    out_ready = '0;
    step();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // ADD/SUB sequence with wrap at prog_len-1
    clear_mem();
    mem[0] = ins(1, 6, 4, 5);
    mem[1] = ins(4, 6, 0, 3);
    mem[2] = ins(5, 6, 0, 10);
    do_reset(5'd3);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_stalled", 32'(stalled), 32'd0);
    push("t1_acc0", 32'h05); push("t1_pc0", 32'd1);
    push("t1_acc1", 32'h08); push("t1_pc1", 32'd2);
    push("t1_acc2", 32'hFE); push("t1_pc2", 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      pop_chk(32'(acc));
      pop_chk(32'(pc));
    end

    // Saturation
    clear_mem();
    mem[0] = ins(1, 6, 4, 120);
    mem[1] = ins(4, 6, 0, 100);
    mem[2] = ins(1, 6, 4, 128);
    mem[3] = ins(6, 0, 0, 0);
    mem[4] = ins(5, 6, 0, 128);
    do_reset(5'd5);
    push("sat_add", 32'h7F); push("sat_min", 32'h80);
    push("sat_neg", 32'h7F); push("sat_sub", 32'h7F);
    step(); step(); pop_chk(32'(acc));
    step(); pop_chk(32'(acc));
    step(); pop_chk(32'(acc));
    step(); pop_chk(32'(acc));

    // SAV / SWP
    clear_mem();
    mem[0] = ins(1, 6, 4, 9);
    mem[1] = ins(3, 0, 0, 0);
    mem[2] = ins(1, 6, 4, 3);
    mem[3] = ins(2, 0, 0, 0);
    mem[4] = ins(2, 0, 0, 0);
    do_reset(5'd5);
    push("swp_a", 32'd9); push("swp_b", 32'd3);
    step(); step(); step(); step(); pop_chk(32'(acc));
    step(); pop_chk(32'(acc));

    // Port read stall
    clear_mem();
    mem[0] = ins(1, 1, 4, 0);
    do_reset(5'd2);
    chk("rd_in_ready0", 32'(in_ready), 32'b0010);
    chk("rd_stalled0", 32'(stalled), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_pc_hold", 32'(pc), 32'd0);
      chk("rd_stalled", 32'(stalled), 32'd1);
      chk("rd_in_ready", 32'(in_ready), 32'b0010);
    end
    in_data = {8'h44, 8'h33, 8'h5A, 8'h11};
    in_valid = 4'b0010;
    push("rd_acc", 32'h5A);
    step();
    in_valid = '0;
    pop_chk(32'(acc));
    chk("rd_pc_adv", 32'(pc), 32'd1);

    // Immediate to port write with back-pressure
    clear_mem();
    mem[0] = ins(1, 6, 2, 42);
    do_reset(5'd2);
    push("wr_word", 32'd42);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("wr_out_valid", 32'(out_valid), 32'b0100);
      chk("wr_out_data", 32'(out_data), 32'd42);
      chk("wr_pc_hold", 32'(pc), 32'd0);
      chk("wr_stalled", 32'(stalled), 32'd1);
      out_ready = 4'b0001;
      step();
    end
    out_ready = 4'b0100;
    #1;
    chk("wr_handshake", 32'(|(out_valid & out_ready)), 32'd1);
    pop_chk(32'(out_data));
    step();
    out_ready = '0;
    chk("wr_done_valid", 32'(out_valid), 32'd0);
    chk("wr_done_pc", 32'(pc), 32'd1);

    // Port to port
    clear_mem();
    mem[0] = ins(1, 0, 3, 0);
    do_reset(5'd2);
    in_data = {8'h44, 8'h33, 8'h22, 8'h33};
    in_valid = 4'b0001;
    push("pp_word", 32'h33);
    #1;
    chk("pp_in_ready", 32'(in_ready), 32'b0001);
    step();
    in_valid = '0;
    chk("pp_out_valid", 32'(out_valid), 32'b1000);
    chk("pp_no_in_ready", 32'(in_ready), 32'd0);
    chk("pp_pc_hold", 32'(pc), 32'd0);
    out_ready = 4'b1000;
    #1;
    pop_chk(32'(out_data));
    step();
    out_ready = '0;
    chk("pp_pc_adv", 32'(pc), 32'd1);
    chk("pp_valid_clr", 32'(out_valid), 32'd0);

    // Jumps with ACC=0
    clear_mem();
    mem[0] = ins(9, 0, 0, 3);
    mem[1] = ins(8, 0, 0, 7);
    mem[4] = ins(7, 0, 0, 2);
    mem[2] = ins(12, 6, 0, 8'hF7);
    do_reset(5'd5);
    push("jnz_untaken", 32'd1); push("jez_clamp", 32'd4);
    push("jmp", 32'd2); push("jro_clamp", 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      pop_chk(32'(pc));
    end

    // prog_len of 0 behaves as 1
    clear_mem();
    mem[0] = ins(4, 6, 0, 1);
    do_reset(5'd0);
    step(); step();
    chk("plen0_pc", 32'(pc), 32'd0);
    chk("plen0_acc", 32'(acc), 32'd2);

    // Reset in WR_WAIT abandons the write
    clear_mem();
    mem[0] = ins(1, 6, 4, 7);
    mem[1] = ins(1, 6, 0, 42);
    do_reset(5'd2);
    step();
    chk("rw_acc", 32'(acc), 32'd7);
    step();
    chk("rw_out_valid", 32'(out_valid), 32'b0001);
    reset = 1'b1;
    out_ready = 4'b0001;
    step();
    chk("rw_valid_drop", 32'(out_valid), 32'd0);
    chk("rw_pc", 32'(pc), 32'd0);
    chk("rw_acc_rst", 32'(acc), 32'd0);
    reset = 1'b0;
    out_ready = '0;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
